robot_motion_ctrl: RTL

Parametrised successor of the robot direction FSM. Adds speed ramping with PWM drive, timed turns that auto-return to the prior heading, and a brake phase on direction reversal. An obstacle clear-hold qualifies restart after a stop. Sits between the command decoder and the motor driver; motor_* outputs drive the H-bridge enables and pwm_out gates them.

---
 rtl/robot_motion_ctrl.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/robot_motion_ctrl.sv
// ---------------------------------------------------------------------------
// robot_motion_ctrl
//   Motion controller between the command decoder and the H-bridge driver.
//   It tracks the heading (IDLE/FWD/BWD), ramps the drive speed toward
//   speed_target, runs timed turns that return to the heading they started
//   from, and brakes to zero speed before any change of direction. After an
//   obstacle stop, restart is allowed only after a run of obstacle-free
//   cycles.
//
// Ports
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   move_fwd, move_bwd   level move commands
//   turn_left/right      level turn commands
//   obstacle             obstacle detected, forces STOP
//   error, recover       fault flag / leave ERROR
//   speed_target         requested cruise speed
//   state                IDLE=0 FWD=1 BWD=2 LEFT=3 RIGHT=4 STOP=5 ERROR=6 BRAKE=7
//   motor_*              H-bridge enables, exactly one high per state
//   pwm_out              speed PWM gating the enables
//   speed_cur            current ramped speed
//   turn_done            one-cycle pulse when a timed turn completes
// ---------------------------------------------------------------------------
module robot_motion_ctrl #(
  parameter int SPEED_W     = 8,
  parameter int RAMP_DIV    = 4,
  parameter int TURN_CYCLES = 16,
  parameter int STOP_HOLD   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               move_fwd,
  input  logic               move_bwd,
  input  logic               turn_left,
  input  logic               turn_right,
  input  logic               obstacle,
  input  logic               error,
  input  logic               recover,
  input  logic [SPEED_W-1:0] speed_target,
  output logic [2:0]         state,
  output logic               motor_fwd,
  output logic               motor_bwd,
  output logic               motor_left,
  output logic               motor_right,
  output logic               motor_stop,
  output logic               pwm_out,
  output logic [SPEED_W-1:0] speed_cur,
  output logic               turn_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FWD   = 3'd1,
    S_BWD   = 3'd2,
    S_LEFT  = 3'd3,
    S_RIGHT = 3'd4,
    S_STOP  = 3'd5,
    S_ERROR = 3'd6,
    S_BRAKE = 3'd7
  } state_t;

  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam int CW = $clog2(STOP_HOLD + 1);

  localparam logic [RW-1:0]      RAMP_LAST = RW'(RAMP_DIV - 1);
  localparam logic [TW-1:0]      TURN_LAST = TW'(TURN_CYCLES - 1);
  localparam logic [CW-1:0]      HOLD_MIN  = CW'(STOP_HOLD);
  localparam logic [SPEED_W-1:0] SPD_ONE   = SPEED_W'(1);

  state_t             state_q, ns;
  state_t             heading, heading_n;   // where a timed turn returns to
  state_t             pending, pending_n;   // direction to take after BRAKE
  state_t             brake_dir, brake_dir_n; // direction being braked
  state_t             cmd, move_from;
  logic               cmd_valid, cmd_move, cmd_turn, turning, tick, done_n;
  logic [RW-1:0]      ramp_cnt;
  logic [TW-1:0]      turn_cnt, turn_cnt_n;
  logic [CW-1:0]      clear_cnt, clear_cnt_n;
  logic [SPEED_W-1:0] pwm_cnt, pwm_cnt_n, speed_n;

  assign state     = state_q;
  assign tick      = (ramp_cnt == RAMP_LAST);
  assign pwm_cnt_n = pwm_cnt + SPD_ONE;
  assign turning   = (state_q == S_LEFT) || (state_q == S_RIGHT);
  assign move_from = turning ? heading : state_q;

  // NOTE: every variable assigned in this block gets a default first so no
  // path through the branches below can infer a latch.
  always_comb begin
    cmd       = S_IDLE;
    cmd_valid = 1'b1;
    if (move_fwd)        cmd = S_FWD;
    else if (move_bwd)   cmd = S_BWD;
    else if (turn_left)  cmd = S_LEFT;
    else if (turn_right) cmd = S_RIGHT;
    else                 cmd_valid = 1'b0;
    cmd_move = cmd_valid && ((cmd == S_FWD) || (cmd == S_BWD));
    cmd_turn = cmd_valid && ((cmd == S_LEFT) || (cmd == S_RIGHT));

    ns          = state_q;
    heading_n   = heading;
    pending_n   = pending;
    brake_dir_n = brake_dir;
    turn_cnt_n  = turn_cnt;
    clear_cnt_n = clear_cnt;
    done_n      = 1'b0;

    if (error) begin
      ns = S_ERROR;
    end else if (state_q == S_ERROR) begin
      if (recover) ns = S_IDLE;
    end else if (obstacle) begin
      ns          = S_STOP;
      clear_cnt_n = '0;
    end else begin
      case (state_q)
        S_STOP: begin
          // The clear counter only needs to reach the hold threshold; it
          // saturates there so a long wait cannot wrap it.
          if (clear_cnt >= HOLD_MIN) begin
            if (cmd_valid) begin
              ns = cmd;
              if (cmd_turn) begin
                heading_n  = S_IDLE;
                turn_cnt_n = '0;
              end
            end
          end else begin
            clear_cnt_n = clear_cnt + CW'(1);
          end
        end
        S_BRAKE: begin
          if (cmd_move) pending_n = cmd;
          if (speed_cur == '0) ns = pending_n;
        end
        default: begin  // IDLE, FWD, BWD, LEFT, RIGHT
          if (cmd_move) begin
            // Reversing a moving heading must pass through BRAKE first.
            if (((move_from == S_FWD) || (move_from == S_BWD)) && (cmd != move_from)) begin
              ns          = S_BRAKE;
              pending_n   = cmd;
              brake_dir_n = move_from;
            end else begin
              ns = cmd;
            end
          end else if (cmd_turn && !turning) begin
            heading_n  = state_q;
            ns         = cmd;
            turn_cnt_n = '0;
          end else if (cmd_turn && (cmd != state_q)) begin
            ns         = cmd;
            turn_cnt_n = '0;
          end else if (turning) begin
            if (turn_cnt == TURN_LAST) begin
              ns     = heading;
              done_n = 1'b1;
            end else begin
              turn_cnt_n = turn_cnt + TW'(1);
            end
          end
        end
      endcase
    end

    // Speed follows the state being entered this edge.
    speed_n = speed_cur;
    case (ns)
      S_FWD, S_BWD: begin
        if (tick) begin
          if (speed_cur < speed_target)      speed_n = speed_cur + SPD_ONE;
          else if (speed_cur > speed_target) speed_n = speed_cur - SPD_ONE;
        end
      end
      S_BRAKE:        if (tick && (speed_cur != '0)) speed_n = speed_cur - SPD_ONE;
      S_LEFT, S_RIGHT: speed_n = speed_cur;
      default:        speed_n = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      heading     <= S_IDLE;
      pending     <= S_IDLE;
      brake_dir   <= S_IDLE;
      ramp_cnt    <= '0;
      turn_cnt    <= '0;
      clear_cnt   <= '0;
      pwm_cnt     <= '0;
      speed_cur   <= '0;
      pwm_out     <= 1'b0;
      turn_done   <= 1'b0;
      motor_fwd   <= 1'b0;
      motor_bwd   <= 1'b0;
      motor_left  <= 1'b0;
      motor_right <= 1'b0;
      motor_stop  <= 1'b1;
    end else begin
      state_q     <= ns;
      heading     <= heading_n;
      pending     <= pending_n;
      brake_dir   <= brake_dir_n;
      ramp_cnt    <= tick ? '0 : ramp_cnt + RW'(1);
      turn_cnt    <= turn_cnt_n;
      clear_cnt   <= clear_cnt_n;
      pwm_cnt     <= pwm_cnt_n;
      speed_cur   <= speed_n;
      turn_done   <= done_n;
      pwm_out     <= (pwm_cnt_n < speed_n) &&
                     (ns inside {S_FWD, S_BWD, S_LEFT, S_RIGHT, S_BRAKE});
      motor_fwd   <= (ns == S_FWD) || ((ns == S_BRAKE) && (brake_dir_n == S_FWD));
      motor_bwd   <= (ns == S_BWD) || ((ns == S_BRAKE) && (brake_dir_n == S_BWD));
      motor_left  <= (ns == S_LEFT);
      motor_right <= (ns == S_RIGHT);
      motor_stop  <= ns inside {S_IDLE, S_STOP, S_ERROR};
    end
  end

endmodule
